// File: rtl/packet_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// packet_stream_rr_arbiter
//
// Packet-level round-robin arbiter that shares one Avalon-ST packet sink between
// NUM_SOURCES packet sources. A source requests by presenting a valid SOP beat.
// The winner is locked from its SOP beat to its EOP beat, and its stream is
// muxed combinationally to the single output. Exactly one IDLE (arbitration)
// cycle separates consecutive packets.
//
// Parameters
//   NUM_SOURCES  number of requesting packet sources (2..16)
//   DATA_WIDTH   data width of every source and of the output
//
// Ports
//   clock_clk               in   single clock, rising edge
//   reset_reset             in   synchronous, active-high reset
//   arb_enable              in   1 = new grants allowed, 0 = finish packet then hold
//   asi_in_data             in   source i data at [i*DATA_WIDTH +: DATA_WIDTH]
//   asi_in_valid            in   per-source valid
//   asi_in_startofpacket    in   per-source SOP
//   asi_in_endofpacket      in   per-source EOP
//   asi_in_ready            out  per-source ready
//   aso_out0_data           out  muxed data
//   aso_out0_valid          out  muxed valid
//   aso_out0_startofpacket  out  muxed SOP
//   aso_out0_endofpacket    out  muxed EOP
//   aso_out0_ready          in   sink ready (readyLatency 0)
//   aso_out0_channel        out  binary index of the granted source
//                                (only when PKT_ARB_CHANNEL_EN is defined)
//   arb_grant               out  one-hot registered grant, 0 when idle
//   arb_busy                out  FSM state: 1 in PKT, 0 in IDLE
//   drop_pulse              out  1-cycle pulse: stray non-SOP beat discarded in IDLE
//
// Handshake: a beat moves across an Avalon-ST interface in every cycle where
// both valid and ready are high; ready does not depend on a pending transfer
// being accepted elsewhere beyond the combinational grant mux below, and valid
// may be withdrawn by a source at any time without side effects.
//
// Optional feature macro: PKT_ARB_CHANNEL_EN adds the aso_out0_channel port.
// -----------------------------------------------------------------------------
module packet_stream_rr_arbiter #(
  parameter int NUM_SOURCES = 4,
  parameter int DATA_WIDTH  = 256
) (
  input  logic                              clock_clk,
  input  logic                              reset_reset,
  input  logic                              arb_enable,
  input  logic [NUM_SOURCES*DATA_WIDTH-1:0] asi_in_data,
  input  logic [NUM_SOURCES-1:0]            asi_in_valid,
  input  logic [NUM_SOURCES-1:0]            asi_in_startofpacket,
  input  logic [NUM_SOURCES-1:0]            asi_in_endofpacket,
  output logic [NUM_SOURCES-1:0]            asi_in_ready,
  output logic [DATA_WIDTH-1:0]             aso_out0_data,
  output logic                              aso_out0_valid,
  output logic                              aso_out0_startofpacket,
  output logic                              aso_out0_endofpacket,
  input  logic                              aso_out0_ready,
`ifdef PKT_ARB_CHANNEL_EN
  output logic [$clog2(NUM_SOURCES)-1:0]    aso_out0_channel,
`endif
  output logic [NUM_SOURCES-1:0]            arb_grant,
  output logic                              arb_busy,
  output logic                              drop_pulse
);

  localparam int PTR_W = $clog2(NUM_SOURCES);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_PKT  = 1'b1
  } state_e;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e                 state_q, state_d;
  logic [NUM_SOURCES-1:0] grant_q, grant_d;
  // last_ptr_q is both the round-robin pointer and the mux select while in
  // PKT: it is only ever loaded with the winner at the moment of a grant, so
  // during a packet it always names the granted source.
  logic [PTR_W-1:0]       last_ptr_q, last_ptr_d;
  logic                   drop_q, drop_d;

  // ---------------------------------------------------------------------------
  // Request decode and rotating-priority winner search
  // ---------------------------------------------------------------------------
  logic [NUM_SOURCES-1:0] req;
  logic [NUM_SOURCES-1:0] stray;
  logic                   win_found;
  logic [PTR_W-1:0]       win_idx;
  logic [PTR_W:0]         cand;

  assign req   = asi_in_valid &  asi_in_startofpacket;
  assign stray = asi_in_valid & ~asi_in_startofpacket;

  // Scan last_ptr+1, last_ptr+2, ... (mod NUM_SOURCES); first requester wins.
  // cand carries one spare bit so the sum cannot overflow before the wrap.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 1; k <= NUM_SOURCES; k++) begin
      cand = {1'b0, last_ptr_q} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_SOURCES)) begin
        cand = cand - (PTR_W+1)'(NUM_SOURCES);
      end
      if (!win_found && req[cand[PTR_W-1:0]]) begin
        win_found = 1'b1;
        win_idx   = cand[PTR_W-1:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Granted-source mux
  // ---------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] sel_data;
  logic                  sel_valid;
  logic                  sel_sop;
  logic                  sel_eop;
  logic                  beat_xfer;

  assign sel_data  = asi_in_data[int'(last_ptr_q)*DATA_WIDTH +: DATA_WIDTH];
  assign sel_valid = asi_in_valid[last_ptr_q];
  assign sel_sop   = asi_in_startofpacket[last_ptr_q];
  assign sel_eop   = asi_in_endofpacket[last_ptr_q];
  assign beat_xfer = sel_valid & aso_out0_ready;

  // ---------------------------------------------------------------------------
  // FSM process 1: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock_clk) begin
    if (reset_reset) begin
      state_q    <= ST_IDLE;
      grant_q    <= '0;
      last_ptr_q <= PTR_W'(NUM_SOURCES - 1);
      drop_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      last_ptr_q <= last_ptr_d;
      drop_q     <= drop_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM process 2: next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    last_ptr_d = last_ptr_q;
    drop_d     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Stray beats are accepted (and discarded) whether or not a grant is
        // made in the same cycle.
        drop_d = |stray;
        if (arb_enable && win_found) begin
          state_d    = ST_PKT;
          grant_d    = {{(NUM_SOURCES-1){1'b0}}, 1'b1} << win_idx;
          last_ptr_d = win_idx;
        end
      end
      ST_PKT: begin
        // SOP flags inside the packet are not inspected; only EOP ends it.
        if (beat_xfer && sel_eop) begin
          state_d = ST_IDLE;
          grant_d = '0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        grant_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM process 3: outputs
  // ---------------------------------------------------------------------------
  // The stream-side outputs are forced low while reset_reset is high, so an
  // interrupted packet stops driving the sink in the same cycle reset arrives.
  always_comb begin
    asi_in_ready           = '0;
    aso_out0_data          = '0;
    aso_out0_valid         = 1'b0;
    aso_out0_startofpacket = 1'b0;
    aso_out0_endofpacket   = 1'b0;
    if (!reset_reset) begin
      unique case (state_q)
        ST_IDLE: begin
          // Requesting SOP beats wait (ready=0); non-SOP beats are drained.
          asi_in_ready = stray;
        end
        ST_PKT: begin
          aso_out0_data          = sel_data;
          aso_out0_valid         = sel_valid;
          aso_out0_startofpacket = sel_sop;
          aso_out0_endofpacket   = sel_eop;
          asi_in_ready           = grant_q & {NUM_SOURCES{aso_out0_ready}};
        end
        default: begin
          asi_in_ready = '0;
        end
      endcase
    end
  end

`ifdef PKT_ARB_CHANNEL_EN
  always_comb begin
    aso_out0_channel = '0;
    if (!reset_reset && (state_q == ST_PKT)) begin
      aso_out0_channel = last_ptr_q;
    end
  end
`endif

  assign arb_grant  = grant_q;
  assign arb_busy   = (state_q == ST_PKT);
  assign drop_pulse = drop_q;

  // ---------------------------------------------------------------------------
  // Structural invariants
  // ---------------------------------------------------------------------------
`ifndef SYNTHESIS
  a_grant_onehot0: assert property (
    @(posedge clock_clk) disable iff (reset_reset) $onehot0(grant_q));

  a_busy_matches_grant: assert property (
    @(posedge clock_clk) disable iff (reset_reset)
      ((state_q == ST_PKT) == (grant_q != '0)));

  a_ptr_in_range: assert property (
    @(posedge clock_clk) disable iff (reset_reset)
      (int'(last_ptr_q) < NUM_SOURCES));

  a_grant_names_ptr: assert property (
    @(posedge clock_clk) disable iff (reset_reset)
      (state_q == ST_PKT) |-> grant_q[last_ptr_q]);
`endif

endmodule

// File: tb/tb_packet_stream_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_packet_stream_rr_arbiter
// Self-checking bench: a table of per-cycle vectors, directed multi-cycle
// sequences, and randomized packet traffic checked against a cycle-level
// reference model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_packet_stream_rr_arbiter;
  localparam int NS = 4;
  localparam int DW = 32;
  localparam int CW = $clog2(NS);

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst     = 1'b1;
  logic en      = 1'b1;
  logic out_rdy = 1'b1;

  logic [NS*DW-1:0] in_data  = '0;
  logic [NS-1:0]    in_valid = '0;
  logic [NS-1:0]    in_sop   = '0;
  logic [NS-1:0]    in_eop   = '0;
  logic [NS-1:0]    in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid, out_sop, out_eop;
  logic [NS-1:0]    grant;
  logic             busy, drop;
`ifdef PKT_ARB_CHANNEL_EN
  logic [CW-1:0]    out_chan;
`endif

  packet_stream_rr_arbiter #(.NUM_SOURCES(NS), .DATA_WIDTH(DW)) dut (
    .clock_clk              (clk),
    .reset_reset            (rst),
    .arb_enable             (en),
    .asi_in_data            (in_data),
    .asi_in_valid           (in_valid),
    .asi_in_startofpacket   (in_sop),
    .asi_in_endofpacket     (in_eop),
    .asi_in_ready           (in_ready),
    .aso_out0_data          (out_data),
    .aso_out0_valid         (out_valid),
    .aso_out0_startofpacket (out_sop),
    .aso_out0_endofpacket   (out_eop),
    .aso_out0_ready         (out_rdy),
`ifdef PKT_ARB_CHANNEL_EN
    .aso_out0_channel       (out_chan),
`endif
    .arb_grant              (grant),
    .arb_busy               (busy),
    .drop_pulse             (drop)
  );

  // ---------------------------------------------------------------------------
  // Bookkeeping
  // ---------------------------------------------------------------------------
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Source drivers: per-source queue of packet lengths, beat position, strays
  // ---------------------------------------------------------------------------
  int pend_q [NS][$];
  int beat   [NS];
  int pkt_no [NS];
  bit stray  [NS];
  int gap_pct = 0;

  task automatic clear_drivers();
    for (int i = 0; i < NS; i++) begin
      pend_q[i].delete();
      beat[i]   = 0;
      stray[i]  = 1'b0;
    end
  endtask

  task automatic drive_inputs();
    for (int i = 0; i < NS; i++) begin
      in_valid[i] = 1'b0;
      in_sop[i]   = 1'b0;
      in_eop[i]   = 1'b0;
      in_data[i*DW +: DW] = '0;
      if (stray[i]) begin
        in_valid[i] = 1'b1;
        in_data[i*DW +: DW] = {8'(i), 8'hEE, 16'hFFFF};
      end else if (pend_q[i].size() > 0) begin
        in_valid[i] = ($urandom_range(99) >= gap_pct);
        in_sop[i]   = (beat[i] == 0);
        in_eop[i]   = (beat[i] == pend_q[i][0] - 1);
        in_data[i*DW +: DW] = {8'(i), 8'(pkt_no[i]), 16'(beat[i])};
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: one owner or none, a round-robin pointer, a drop flag
  // ---------------------------------------------------------------------------
  bit m_busy  = 1'b0;
  int m_owner = 0;
  int m_last  = NS - 1;
  bit m_drop  = 1'b0;
  logic [NS-1:0] xfer_ready;

  // observed values of the current cycle, for sequence-level checks
  logic [NS-1:0] obs_grant;
  logic [DW-1:0] obs_data;
  logic          obs_valid;
  int            obs_chan;

  // scoreboard of expected output beats {sop, eop, data}
  logic [DW+1:0] exp_q[$];
  bit sb_on = 1'b0;

  task automatic eval_and_check();
    logic [NS-1:0] e_ready, e_grant;
    logic [DW-1:0] e_data;
    logic          e_valid, e_sop, e_eop;
    int            e_chan;
    logic [DW+1:0] e_beat;
    e_grant = m_busy ? (NS'(1) << m_owner) : '0;
    e_ready = '0;
    e_data  = '0;
    e_valid = 1'b0;
    e_sop   = 1'b0;
    e_eop   = 1'b0;
    e_chan  = 0;
    if (!rst) begin
      if (m_busy) begin
        e_data         = in_data[m_owner*DW +: DW];
        e_valid        = in_valid[m_owner];
        e_sop          = in_sop[m_owner];
        e_eop          = in_eop[m_owner];
        e_ready[m_owner] = out_rdy;
        e_chan         = m_owner;
      end else begin
        e_ready = in_valid & ~in_sop;
      end
    end
    check("grant",     64'(grant),     64'(e_grant));
    check("busy",      64'(busy),      64'(m_busy));
    check("drop",      64'(drop),      64'(m_drop));
    check("in_ready",  64'(in_ready),  64'(e_ready));
    check("out_valid", 64'(out_valid), 64'(e_valid));
    check("out_data",  64'(out_data),  64'(e_data));
    check("out_sop",   64'(out_sop),   64'(e_sop));
    check("out_eop",   64'(out_eop),   64'(e_eop));
`ifdef PKT_ARB_CHANNEL_EN
    check("out_chan",  64'(out_chan),  64'(e_chan));
    obs_chan = int'(out_chan);
`else
    obs_chan = e_chan;
`endif
    xfer_ready = e_ready;
    obs_grant  = grant;
    obs_data   = out_data;
    obs_valid  = out_valid;
    if (sb_on && out_valid && out_rdy) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_beat", 64'(1), 64'(0));
      end else begin
        e_beat = exp_q.pop_front();
        check("sb_beat", 64'({out_sop, out_eop, out_data}), 64'(e_beat));
      end
    end
  endtask

  task automatic model_update();
    logic [NS-1:0] req;
    bit found;
    int idx;
    req = in_valid & in_sop;
    if (rst) begin
      m_busy = 1'b0;
      m_last = NS - 1;
      m_drop = 1'b0;
    end else if (m_busy) begin
      m_drop = 1'b0;
      if (in_valid[m_owner] && out_rdy && in_eop[m_owner]) m_busy = 1'b0;
    end else begin
      m_drop = |(in_valid & ~in_sop);
      if (en && (req != '0)) begin
        found = 1'b0;
        for (int k = 1; k <= NS; k++) begin
          idx = (m_last + k) % NS;
          if (!found && req[idx]) begin
            found   = 1'b1;
            m_owner = idx;
          end
        end
        m_last = m_owner;
        m_busy = 1'b1;
      end
    end
  endtask

  task automatic driver_update();
    for (int i = 0; i < NS; i++) begin
      if (xfer_ready[i] && in_valid[i]) begin
        if (stray[i]) begin
          stray[i] = 1'b0;
        end else if (pend_q[i].size() > 0) begin
          beat[i]++;
          if (beat[i] == pend_q[i][0]) begin
            void'(pend_q[i].pop_front());
            beat[i] = 0;
            pkt_no[i]++;
          end
        end
      end
    end
  endtask

  // One clock cycle: drive after the falling edge, check 1 ns later, advance
  // the model on the rising edge.
  task automatic step(input logic r, input logic e, input logic o);
    @(negedge clk);
    rst     = r;
    en      = e;
    out_rdy = o;
    drive_inputs();
    #1;
    eval_and_check();
    @(posedge clk);
    model_update();
    driver_update();
  endtask

  task automatic do_reset();
    clear_drivers();
    repeat (2) step(1'b1, 1'b1, 1'b1);
  endtask

  // ---------------------------------------------------------------------------
  // Vector table
  // ---------------------------------------------------------------------------
  typedef struct {
    logic [NS-1:0] v, s, e;
    logic          ordy, enb;
    logic [NS-1:0] x_grant, x_ready;
    logic          x_valid, x_drop;
    int            x_src;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [NS-1:0] v, s, e, input logic ordy, enb,
                     input logic [NS-1:0] xg, xr, input logic xv, xd, input int xs);
    vec_t r;
    r.v = v; r.s = s; r.e = e; r.ordy = ordy; r.enb = enb;
    r.x_grant = xg; r.x_ready = xr; r.x_valid = xv; r.x_drop = xd; r.x_src = xs;
    tbl.push_back(r);
  endtask

  // ---------------------------------------------------------------------------
  // Watchdog
  // ---------------------------------------------------------------------------
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    logic [NS-1:0] g2 [12];
    logic [DW-1:0] exp_data;

    clear_drivers();
    for (int i = 0; i < NS; i++) pkt_no[i] = 0;

    // 1: reset held 3 cycles with every source presenting valid+SOP
    for (int i = 0; i < NS; i++) pend_q[i].push_back(1);
    repeat (3) begin
      step(1'b1, 1'b1, 1'b1);
      check("t1_reset_grant", 64'(obs_grant), 64'(0));
      check("t1_reset_valid", 64'(obs_valid), 64'(0));
    end
    clear_drivers();

    // Table: single-source service cadence, stray drop, wrap, stall, enable
    //   v        s        e        ordy enb grant    ready    val drop src
    add(4'b0100, 4'b0100, 4'b0100, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0100, 4'b0100, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 0,  2);
    add(4'b0100, 4'b0100, 4'b0100, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0100, 4'b0100, 4'b0100, 1, 1, 4'b0100, 4'b0100, 1, 0,  2);
    add(4'b1000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b1000, 0, 0, -1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 1, -1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b1001, 4'b1001, 4'b1001, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b1001, 4'b1001, 4'b1001, 1, 1, 4'b1000, 4'b1000, 1, 0,  3);
    add(4'b1001, 4'b1001, 4'b1001, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b1001, 4'b1001, 4'b1001, 1, 1, 4'b0001, 4'b0001, 1, 0,  0);
    add(4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0010, 4'b0010, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0010, 4'b0010, 4'b0000, 0, 1, 4'b0010, 4'b0000, 1, 0,  1);
    add(4'b0010, 4'b0010, 4'b0000, 1, 1, 4'b0010, 4'b0010, 1, 0,  1);
    add(4'b0010, 4'b0000, 4'b0010, 1, 1, 4'b0010, 4'b0010, 1, 0,  1);
    add(4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0001, 4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0001, 4'b0001, 4'b0001, 1, 0, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0001, 4'b0001, 4'b0001, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);
    add(4'b0001, 4'b0001, 4'b0001, 1, 1, 4'b0001, 4'b0001, 1, 0,  0);
    add(4'b0101, 4'b0001, 4'b0101, 1, 1, 4'b0000, 4'b0100, 0, 0, -1);
    add(4'b0001, 4'b0001, 4'b0001, 1, 1, 4'b0001, 4'b0001, 1, 1,  0);
    add(4'b0000, 4'b0000, 4'b0000, 1, 1, 4'b0000, 4'b0000, 0, 0, -1);

    for (int r = 0; r < tbl.size(); r++) begin
      @(negedge clk);
      rst      = 1'b0;
      en       = tbl[r].enb;
      out_rdy  = tbl[r].ordy;
      in_valid = tbl[r].v;
      in_sop   = tbl[r].s;
      in_eop   = tbl[r].e;
      for (int i = 0; i < NS; i++) in_data[i*DW +: DW] = 32'hD000_0000 + DW'(i);
      #1;
      exp_data = (tbl[r].x_src >= 0) ? 32'hD000_0000 + DW'(tbl[r].x_src) : '0;
      check($sformatf("tbl%0d_grant", r), 64'(grant), 64'(tbl[r].x_grant));
      check($sformatf("tbl%0d_ready", r), 64'(in_ready), 64'(tbl[r].x_ready));
      check($sformatf("tbl%0d_valid", r), 64'(out_valid), 64'(tbl[r].x_valid));
      check($sformatf("tbl%0d_drop", r), 64'(drop), 64'(tbl[r].x_drop));
      check($sformatf("tbl%0d_data", r), 64'(out_data), 64'(exp_data));
`ifdef PKT_ARB_CHANNEL_EN
      check($sformatf("tbl%0d_chan", r), 64'(out_chan),
            64'((tbl[r].x_src >= 0) ? tbl[r].x_src : 0));
`endif
      @(posedge clk);
      model_update();
    end

    // 2: all four sources send a 2-beat packet at once
    do_reset();
    for (int i = 0; i < NS; i++) pkt_no[i] = 0;
    for (int i = 0; i < NS; i++) begin
      pend_q[i].push_back(2);
      for (int b = 0; b < 2; b++)
        exp_q.push_back({(b == 0), (b == 1), 8'(i), 8'(0), 16'(b)});
    end
    g2 = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h0, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8};
    sb_on = 1'b1;
    for (int c = 0; c < 12; c++) begin
      step(1'b0, 1'b1, 1'b1);
      check($sformatf("t2_grant_c%0d", c), 64'(obs_grant), 64'(g2[c]));
    end
    step(1'b0, 1'b1, 1'b1);
    check("t2_all_beats_out", 64'(exp_q.size()), 64'(0));
    check("t2_idle_after", 64'(obs_grant), 64'(0));
    sb_on = 1'b0;

    // 4: src1 3-beat packet, sink stalls on its second beat; src2 waiting
    pend_q[1].push_back(3);
    pend_q[2].push_back(1);
    step(1'b0, 1'b1, 1'b1);                  // arbitration cycle, src1 wins
    step(1'b0, 1'b1, 1'b1);                  // beat 0
    for (int c = 0; c < 2; c++) begin
      step(1'b0, 1'b1, 1'b0);                // stalled beat 1
      check("t4_stall_grant", 64'(obs_grant), 64'(4'b0010));
      check("t4_stall_data", 64'(obs_data), 64'({8'd1, 8'd1, 16'd1}));
    end
    step(1'b0, 1'b1, 1'b1);                  // beat 1
    step(1'b0, 1'b1, 1'b1);                  // beat 2 (eop)
    check("t4_last_beat", 64'(obs_data), 64'({8'd1, 8'd1, 16'd2}));
    step(1'b0, 1'b1, 1'b1);                  // arbitration, src2 wins
    step(1'b0, 1'b1, 1'b1);
    check("t4_src2_after", 64'(obs_grant), 64'(4'b0100));

    // 6: arb_enable dropped during a src0 4-beat packet
    pend_q[0].push_back(4);
    step(1'b0, 1'b1, 1'b1);                  // grant src0
    pend_q[1].push_back(1);
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b0, 1'b1);
      check("t6_beat_valid", 64'(obs_valid), 64'(1));
      check("t6_beat_chan", 64'(obs_chan), 64'(0));
    end
    repeat (3) begin
      step(1'b0, 1'b0, 1'b1);
      check("t6_hold_idle", 64'(obs_grant), 64'(0));
    end
    step(1'b0, 1'b1, 1'b1);                  // arbitration with enable back
    step(1'b0, 1'b1, 1'b1);
    check("t6_src1_grant", 64'(obs_grant), 64'(4'b0010));
    check("t6_src1_chan", 64'(obs_chan), 64'(1));

    // Reset in the middle of a src3 packet; pointer restarts at source 0
    pend_q[3].push_back(3);
    step(1'b0, 1'b1, 1'b1);                  // grant src3
    step(1'b0, 1'b1, 1'b1);                  // beat 0
    step(1'b1, 1'b1, 1'b1);                  // reset arrives mid-packet
    check("rst_mid_valid", 64'(obs_valid), 64'(0));
    clear_drivers();
    step(1'b0, 1'b1, 1'b1);
    check("rst_mid_grant", 64'(obs_grant), 64'(0));
    pend_q[0].push_back(1);
    pend_q[3].push_back(1);
    step(1'b0, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1);
    check("rst_ptr_src0_first", 64'(obs_grant), 64'(4'b0001));
    repeat (4) step(1'b0, 1'b1, 1'b1);

    // Randomized traffic against the model
    gap_pct = 20;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NS; i++) begin
        if (pend_q[i].size() == 0 && !stray[i]) begin
          int r;
          r = $urandom_range(99);
          if (r < 10)      pend_q[i].push_back($urandom_range(1, 4));
          else if (r < 13) stray[i] = 1'b1;
        end
      end
      step(($urandom_range(199) == 0), ($urandom_range(9) != 0), ($urandom_range(3) != 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
